// File: rtl/rice_bit_packer.sv
// rice_bit_packer: serializes Rice codewords (unary q, stop bit, rp-bit remainder) MSB-first into 16-bit words.
// Ports: iClock/iReset (async active-low); iValid/iMSB/iLSB/iRiceParam codeword in, oReady accept;
//        iFlush pads and emits the partial word; oData/oValid packed word; oFlushDone flush complete;
//        oBitCount bits appended since reset, padding excluded.
module rice_bit_packer #(
    parameter int WORD_WIDTH  = 16,
    parameter int PARAM_WIDTH = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic                   iValid,
    input  logic [WORD_WIDTH-1:0]  iMSB,
    input  logic [WORD_WIDTH-1:0]  iLSB,
    input  logic [PARAM_WIDTH-1:0] iRiceParam,
    input  logic                   iFlush,
    output logic                   oReady,
    output logic [WORD_WIDTH-1:0]  oData,
    output logic                   oValid,
    output logic                   oFlushDone,
    output logic [COUNT_WIDTH-1:0] oBitCount
);
    localparam int W = WORD_WIDTH;

    typedef enum logic [1:0] {IDLE, UNARY, TAIL, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           fill_q, fill_d;
    logic [W-1:0]           buf_q, buf_d;
    logic [W-1:0]           zeros_q, zeros_d;
    logic [W-1:0]           rem_q, rem_d;
    logic [PARAM_WIDTH-1:0] rp_q, rp_d;
    logic                   flush_q, flush_d;
    logic [W-1:0]           data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]           room, n, len, val, sum;
    logic [W:0]             sh;
    logic [2*W-1:0]         cat;

    assign room = W'(W) - fill_q;
    assign n    = (zeros_q < room) ? zeros_q : room;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        buf_d   = buf_q;
        zeros_d = zeros_q;
        rem_d   = rem_q;
        rp_d    = rp_q;
        flush_d = iFlush | (flush_q & (state_q != FLUSH));
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        len     = '0;
        val     = '0;
        case (state_q)
            IDLE: begin
                if (iValid) begin
                    zeros_d = iMSB;
                    rem_d   = iLSB & ((W'(1) << iRiceParam) - W'(1));
                    rp_d    = iRiceParam;
                    state_d = (iMSB != '0) ? UNARY : TAIL;
                end else if (flush_q) begin
                    state_d = FLUSH;
                end
            end
            UNARY: begin
                len     = n;
                zeros_d = zeros_q - n;
                state_d = (zeros_q == n) ? TAIL : UNARY;
            end
            TAIL: begin
                len     = W'(rp_q) + W'(1);
                val     = (W'(1) << rp_q) | rem_q;
                state_d = flush_q ? FLUSH : IDLE;
            end
            default: begin
                if (fill_q != '0) begin
                    data_d  = buf_q;
                    valid_d = 1'b1;
                end
                buf_d   = '0;
                fill_d  = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
        // Buffer is left-justified with zeros below fill; the new field lands right under it.
        sh  = (W+1)'(2*W) - {1'b0, fill_q} - {1'b0, len};
        cat = {buf_q, {W{1'b0}}} | ({{W{1'b0}}, val} << sh);
        sum = fill_q + len;
        if (len != '0) begin
            cnt_d  = cnt_q + COUNT_WIDTH'(len);
            buf_d  = (sum >= W'(W)) ? cat[W-1:0] : cat[2*W-1:W];
            fill_d = (sum >= W'(W)) ? sum - W'(W) : sum;
            if (sum >= W'(W)) begin
                data_d  = cat[2*W-1:W];
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= IDLE;
            fill_q  <= '0;
            buf_q   <= '0;
            zeros_q <= '0;
            rem_q   <= '0;
            rp_q    <= '0;
            flush_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
            zeros_q <= zeros_d;
            rem_q   <= rem_d;
            rp_q    <= rp_d;
            flush_q <= flush_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oReady     = (state_q == IDLE);
    assign oData      = data_q;
    assign oValid     = valid_q;
    assign oFlushDone = done_q;
    assign oBitCount  = cnt_q;
endmodule

// File: tb/tb_rice_bit_packer.sv
// tb_rice_bit_packer: scoreboard bench for rice_bit_packer
module tb_rice_bit_packer;
    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic        iValid = 1'b0;
    logic [15:0] iMSB = '0;
    logic [15:0] iLSB = '0;
    logic [3:0]  iRiceParam = '0;
    logic        iFlush = 1'b0;
    logic        oReady;
    logic [15:0] oData;
    logic        oValid;
    logic        oFlushDone;
    logic [31:0] oBitCount;

    int compared = 0;
    int mismatched = 0;
    logic [17:0] exp_q[$];

    rice_bit_packer dut (
        .iClock(iClock), .iReset(iReset), .iValid(iValid), .iMSB(iMSB), .iLSB(iLSB),
        .iRiceParam(iRiceParam), .iFlush(iFlush), .oReady(oReady), .oData(oData),
        .oValid(oValid), .oFlushDone(oFlushDone), .oBitCount(oBitCount)
    );

    always #5 iClock = ~iClock;

    // Scoreboard: every output event {oValid, oFlushDone, oData} must match the next queued entry.
    always @(negedge iClock) begin
        if (iReset && (oValid || oFlushDone)) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL spurious_output: got valid=%0b done=%0b data=%h, expected nothing", oValid, oFlushDone, oData);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({oValid, oFlushDone, oData} !== e) begin
                    mismatched++;
                    $display("FAIL word: got valid=%0b done=%0b data=%h, expected valid=%0b done=%0b data=%h",
                             oValid, oFlushDone, oData, e[17], e[16], e[15:0]);
                end
            end
        end
    end

    task automatic apply_reset();
        iValid = 0;
        iFlush = 0;
        iReset = 0;
        exp_q.delete();
        repeat (2) @(negedge iClock);
        iReset = 1;
        @(negedge iClock);
    endtask

    task automatic send(input logic [15:0] q, input logic [3:0] rp, input logic [15:0] rem);
        int t = 0;
        @(negedge iClock);
        while (!oReady && t < 200) begin
            @(negedge iClock);
            t++;
        end
        compared++;
        if (!oReady) begin
            mismatched++;
            $display("FAIL ready_timeout: oReady=%0b, expected 1", oReady);
        end
        iMSB = q;
        iRiceParam = rp;
        iLSB = rem;
        iValid = 1;
        @(posedge iClock);
        #1 iValid = 0;
    endtask

    task automatic flush();
        @(negedge iClock);
        iFlush = 1;
        @(posedge iClock);
        #1 iFlush = 0;
    endtask

    task automatic drain(input string name, input logic [31:0] bits);
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge iClock);
            t++;
        end
        repeat (6) @(negedge iClock);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
        end
        compared++;
        if (oBitCount !== bits) begin
            mismatched++;
            $display("FAIL %s_bitcount: got %0d, expected %0d", name, oBitCount, bits);
        end
    endtask

    task automatic check_idle(input string name);
        compared++;
        if ({oReady, oValid, oFlushDone, oData, oBitCount} !== {1'b1, 1'b0, 1'b0, 16'h0, 32'h0}) begin
            mismatched++;
            $display("FAIL %s: got ready=%0b valid=%0b done=%0b data=%h count=%0d, expected 1 0 0 0000 0",
                     name, oReady, oValid, oFlushDone, oData, oBitCount);
        end
    endtask

    task automatic test_reset();
        iReset = 0;
        #2 check_idle("reset_state");
        apply_reset();
        check_idle("after_release");
        exp_q.push_back({2'b10, 16'h0000});
        exp_q.push_back({2'b10, 16'h0000});
        send(40, 0, 0);
        repeat (3) @(negedge iClock);
        compared++;
        if (oBitCount !== 32) begin
            mismatched++;
            $display("FAIL mid_unary_count: got %0d, expected 32", oBitCount);
        end
        #1 iReset = 0;
        #1 check_idle("async_reset");
        exp_q.delete();
        @(negedge iClock);
        iReset = 1;
    endtask

    task automatic test_long_unary();
        apply_reset();
        exp_q.push_back({2'b10, 16'h0000});
        exp_q.push_back({2'b10, 16'h0000});
        exp_q.push_back({2'b11, 16'h0080});
        send(40, 0, 0);
        flush();
        drain("long_unary", 41);
    endtask

    task automatic test_pack();
        apply_reset();
        exp_q.push_back({2'b11, 16'hD9A0});
        send(0, 4, 16'h000B);
        send(2, 3, 16'hFFF5);
        flush();
        drain("pack_mask", 11);
    endtask

    task automatic test_straddle();
        apply_reset();
        exp_q.push_back({2'b10, 16'h001D});
        exp_q.push_back({2'b11, 16'h5000});
        send(11, 0, 0);
        send(0, 7, 16'h0055);
        flush();
        drain("straddle", 20);
    endtask

    task automatic test_boundary();
        apply_reset();
        exp_q.push_back({2'b10, 16'hFFFF});
        send(0, 15, 16'h7FFF);
        drain("full_word", 16);
        exp_q.push_back({2'b01, 16'hFFFF});
        flush();
        drain("empty_flush", 16);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        exp_q.push_back({2'b11, 16'hC000});
        @(negedge iClock);
        iMSB = 0;
        iRiceParam = 1;
        iLSB = 1;
        iValid = 1;
        iFlush = 1;
        @(posedge iClock);
        #1 iFlush = 0;
        compared++;
        if (oReady !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_ready: got %0b, expected 0", oReady);
        end
        repeat (2) @(posedge iClock);
        #1 iValid = 0;
        drain("valid_flush", 2);
    endtask

    initial begin
        test_reset();
        test_long_unary();
        test_pack();
        test_straddle();
        test_boundary();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
